// File: rtl/alu_issue_ctrl.sv
// Issue stage for alu_32bit: an operation FIFO feeds registered ALU operands, and the result is captured into a held valid/ready output.
// Optional macro ALU_ISSUE_STATS_EN adds the 32-bit accepted-result counter port op_count.
module alu_issue_ctrl #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_f,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_f,
    input  logic [WIDTH-1:0] alu_y,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_y,
    output logic [2:0]       res_f,
    output logic             res_zero,
`ifdef ALU_ISSUE_STATS_EN
    output logic [31:0]      op_count,
`endif
    output logic             busy
);

    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int ENT = 3 + 2 * WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_OUT} state_t;

    state_t             r_state, w_state_nxt;
    logic [ENT-1:0]     r_mem [DEPTH];
    logic [PW-1:0]      r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic [WIDTH-1:0]   r_alu_a, r_alu_b, r_res_y;
    logic [2:0]         r_alu_f, r_res_f;
    logic               r_res_valid, r_res_zero;
    logic               w_push, w_pop, w_load, w_res_clr;
    logic [ENT-1:0]     w_head;

    assign in_ready  = (r_count != CW'(DEPTH));
    assign w_push    = in_valid && in_ready;
    assign w_head    = r_mem[r_rd_ptr];
    assign busy      = (r_state != S_IDLE) || (r_count != '0);
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_f     = r_alu_f;
    assign res_valid = r_res_valid;
    assign res_y     = r_res_y;
    assign res_f     = r_res_f;
    assign res_zero  = r_res_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // In S_OUT the count is already post-pop, so a non-empty FIFO chains straight into the next op.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (r_count != '0) w_state_nxt = S_EXEC;
            S_EXEC:  w_state_nxt = S_OUT;
            S_OUT:   if (res_ready) w_state_nxt = (r_count != '0) ? S_EXEC : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_load    = 1'b0;
        w_pop     = 1'b0;
        w_res_clr = 1'b0;
        case (r_state)
            S_IDLE:  w_load = (r_count != '0);
            S_EXEC:  w_pop  = 1'b1;
            S_OUT: begin
                w_res_clr = res_ready;
                w_load    = res_ready && (r_count != '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {in_f, in_a, in_b};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a <= '0;
            r_alu_b <= '0;
            r_alu_f <= '0;
        end else if (w_load) begin
            {r_alu_f, r_alu_a, r_alu_b} <= w_head;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_res_y     <= '0;
            r_res_f     <= '0;
            r_res_zero  <= 1'b0;
        end else if (w_pop) begin
            r_res_valid <= 1'b1;
            r_res_y     <= alu_y;
            r_res_f     <= r_alu_f;
            r_res_zero  <= (alu_y == '0);
        end else if (w_res_clr) begin
            r_res_valid <= 1'b0;
        end
    end

`ifdef ALU_ISSUE_STATS_EN
    logic [31:0] r_op_count;
    assign op_count = r_op_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       r_op_count <= '0;
        else if (r_res_valid && res_ready) r_op_count <= r_op_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: driver pushes expected {f,y} on each accepted op, monitor compares held results.
module tb_alu_issue_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_a, in_b;
    logic [2:0]  in_f;
    logic [31:0] alu_a, alu_b, alu_y;
    logic [2:0]  alu_f;
    logic        res_valid, res_ready, res_zero, busy;
    logic [31:0] res_y;
    logic [2:0]  res_f;
`ifdef ALU_ISSUE_STATS_EN
    logic [31:0] op_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    typedef struct { logic [2:0] f; logic [31:0] y; } exp_t;
    exp_t sb[$];

    // Hand-computed vectors: f, a, b, expected y
    logic [2:0]  v_f [10] = '{3'b010, 3'b000, 3'b001, 3'b110, 3'b011,
                              3'b010, 3'b110, 3'b111, 3'b000, 3'b001};
    logic [31:0] v_a [10] = '{32'h1, 32'hFF00, 32'hF000, 32'h10, 32'hFFFF,
                              32'hFFFFFFFF, 32'h0, 32'hAAAA5555, 32'h12345678, 32'h0};
    logic [31:0] v_b [10] = '{32'h2, 32'h0F0F, 32'h000F, 32'h3, 32'h00FF,
                              32'h1, 32'h1, 32'hFFFF0000, 32'hFFFF0000, 32'h0};
    logic [31:0] v_y [10] = '{32'h3, 32'h0F00, 32'hF00F, 32'hD, 32'hFF00,
                              32'h0, 32'hFFFFFFFF, 32'h55555555, 32'h12340000, 32'h0};

    alu_issue_ctrl #(.WIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_f(in_f),
        .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_y(alu_y),
        .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y),
        .res_f(res_f), .res_zero(res_zero),
`ifdef ALU_ISSUE_STATS_EN
        .op_count(op_count),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (alu_f)
            3'b000:  alu_y = alu_a & alu_b;
            3'b001:  alu_y = alu_a | alu_b;
            3'b010:  alu_y = alu_a + alu_b;
            3'b110:  alu_y = alu_a - alu_b;
            default: alu_y = alu_a ^ alu_b;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compares every held cycle against the head, so a result that drifts while stalled is caught too.
    always @(negedge clk) begin
        if (rst_n && res_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_result: got y=%h f=%h with empty scoreboard", res_y, res_f);
            end else begin
                chk("res_y", res_y, sb[0].y);
                chk("res_f", {29'd0, res_f}, {29'd0, sb[0].f});
                chk("res_zero", {31'd0, res_zero}, {31'd0, (sb[0].y == 32'd0)});
                if (res_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic push_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] y);
        int t = 0;
        bit acc = 1'b0;
        in_valid = 1'b1; in_f = f; in_a = a; in_b = b;
        do begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1; t++;
        end while (!acc && t < 200);
        if (acc) sb.push_back('{f: f, y: y});
        else chk("push_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_empty(input int limit);
        int t = 0;
        while ((sb.size() != 0) && t < limit) begin @(posedge clk); #1; t++; end
        chk("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_f = '0; res_ready = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_res_y", res_y, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Single op and latency
        res_ready = 1'b1;
        push_op(3'b010, 32'h1000000f, 32'h11000005, 32'h21000014);
        chk("lat_alu_a", alu_a, 32'd0);
        chk("lat_res_valid_n1", {31'd0, res_valid}, 32'd0);
        @(posedge clk); #1;
        chk("lat_alu_a_loaded", alu_a, 32'h1000000f);
        chk("lat_alu_b_loaded", alu_b, 32'h11000005);
        chk("lat_res_valid_n1b", {31'd0, res_valid}, 32'd0);
        @(posedge clk); #1;
        chk("lat_res_valid_n2", {31'd0, res_valid}, 32'd1);
        wait_empty(20);

        // Zero flag
        push_op(3'b110, 32'h5, 32'h5, 32'h0);
        push_op(3'b000, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h0);
        wait_empty(20);
        repeat (2) @(posedge clk); #1;
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Backpressure / full
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_op(v_f[i], v_a[i], v_b[i], v_y[i]);
        repeat (3) @(posedge clk); #1;
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        chk("full_busy", {31'd0, busy}, 32'd1);
        chk("full_res_valid", {31'd0, res_valid}, 32'd1);
        res_ready = 1'b1;
        for (int t = 0; t < 40 && sb.size() != 0; t++) begin
            @(negedge clk);
            if (sb.size() != 0) chk("busy_while_draining", {31'd0, busy}, 32'd1);
        end
        chk("bp_drained", sb.size(), 0);
        @(negedge clk);
        chk("busy_after_last", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;

        // Reset while in S_EXEC with 3 ops queued
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_op(v_f[i], v_a[i], v_b[i], v_y[i]);
        repeat (2) @(posedge clk); #1;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("midrst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        res_ready = 1'b1;
        repeat (8) @(posedge clk); #1;
        chk("post_rst_no_result", {31'd0, res_valid}, 32'd0);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        // Streaming with wrap
        for (int i = 0; i < 10; i++) push_op(v_f[i], v_a[i], v_b[i], v_y[i]);
        wait_empty(60);
        @(posedge clk); #1;
`ifdef ALU_ISSUE_STATS_EN
        chk("op_count_10", op_count, 32'd10);
        force dut.r_op_count = 32'hFFFFFFFF;
        @(posedge clk); #1;
        release dut.r_op_count;
        push_op(3'b001, 32'h1, 32'h2, 32'h3);
        wait_empty(20);
        @(posedge clk); #1;
        chk("op_count_wrap", op_count, 32'd0);
`endif
        chk("end_busy", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
